mem_access_arbiter: RTL and testbench

Parametrised arbiter for the CiM temporary-result memory. It generalises the one-hot read/write request scheme to N sources, with selectable fixed-priority or round-robin arbitration. It adds per-source grant handshakes, a tagged pipelined read-data return and contention/error monitoring. It sits between the CiM sub-FSMs/compute units (bus FSM, logic FSM, data fill, dense broadcast save, MAC, layernorm, softmax) and a single-port SRAM macro.

---
 rtl/mem_access_arbiter_if.sv | 50 +++++
 rtl/mem_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Bundle of request, grant, SRAM and status signals around the CiM
// temporary-result memory arbiter.
//
// Handshake: a source holds read_req/write_req (with addr/wdata stable) until
// it sees its grant bit. Grant is a single-cycle pulse. A request still high
// in the cycle after grant is a new access. Read data comes back later as a
// one-cycle rd_valid pulse tagged with the requester's bit. There is no
// backpressure on the return path.
interface mem_access_arbiter_if #(
  parameter int NUM_SRC = 7,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
);
  // Requester side.
  logic                       arb_mode;
  logic [NUM_SRC-1:0]         read_req;
  logic [NUM_SRC-1:0]         write_req;
  logic [NUM_SRC*ADDR_W-1:0]  addr_table;
  logic [NUM_SRC*DATA_W-1:0]  write_data;
  logic [NUM_SRC-1:0]         grant;
  logic [NUM_SRC-1:0]         rd_valid;
  logic [DATA_W-1:0]          rd_data;

  // SRAM macro side.
  logic                       mem_en;
  logic                       mem_wen;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [DATA_W-1:0]          mem_rdata;

  // Monitoring and debug.
  logic [CNT_W-1:0]           contention_cnt;
  logic                       illegal_req;
  logic                       dbg_state;

  // Arbiter view.
  modport master (
    input  arb_mode, read_req, write_req, addr_table, write_data, mem_rdata,
    output grant, rd_valid, rd_data, mem_en, mem_wen, mem_addr, mem_wdata,
    output contention_cnt, illegal_req, dbg_state
  );

  // Environment view: requesters plus the SRAM macro.
  modport slave (
    output arb_mode, read_req, write_req, addr_table, write_data, mem_rdata,
    input  grant, rd_valid, rd_data, mem_en, mem_wen, mem_addr, mem_wdata,
    input  contention_cnt, illegal_req, dbg_state
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// N-source arbiter for the single-port CiM temporary-result SRAM.
// It offers fixed-priority or round-robin selection, a registered SRAM command,
// a tagged read-return pipeline aligned to the SRAM read latency, and
// contention and illegal-request monitoring.
module mem_access_arbiter #(
  parameter int NUM_SRC = 7,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_arbiter_if.master  bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // ISSUE means a grant and an SRAM command are on the outputs this cycle.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                         r_state;
  logic [NUM_SRC-1:0]             r_grant;
  logic                           r_wen;
  logic [ADDR_W-1:0]              r_addr;
  logic [DATA_W-1:0]              r_wdata;
  logic [IDX_W-1:0]               r_last;
  logic [RD_LAT-1:0][NUM_SRC-1:0] r_tag;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_illegal;

  logic [NUM_SRC-1:0]             w_req;
  logic [NUM_SRC-1:0]             w_eligible;
  logic [NUM_SRC-1:0]             w_win_oh;
  logic [IDX_W-1:0]               w_win_idx;
  logic [IDX_W-1:0]               w_sel;
  logic                           w_found;
  int                             w_start;
  int                             w_pos;
  logic                           w_win_write;
  logic [ADDR_W-1:0]              w_win_addr;
  logic [DATA_W-1:0]              w_win_wdata;
  logic [NUM_SRC-1:0]             w_rd_push;
  logic                           w_contended;
  logic                           w_illegal_now;

  // A read and a write together collapse into one write request. A source
  // that holds a grant this cycle is excluded, so it cannot be issued twice.
  assign w_req         = bus.read_req | bus.write_req;
  assign w_eligible    = w_req & ~r_grant;
  assign w_contended   = ($countones(w_eligible) > 1);
  assign w_illegal_now = |(bus.read_req & bus.write_req);

  // Pick the winner. Fixed mode scans upward from 0. Round-robin scans from
  // the slot after the last winner and wraps.
  always_comb begin
    w_win_oh  = '0;
    w_win_idx = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    w_sel     = '0;
    w_start   = (int'(r_last) >= NUM_SRC - 1) ? 0 : int'(r_last) + 1;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_pos = bus.arb_mode ? ((w_start + k) % NUM_SRC) : k;
      w_sel = w_pos[IDX_W-1:0];
      if (!w_found && w_eligible[w_sel]) begin
        w_found          = 1'b1;
        w_win_idx        = w_sel;
        w_win_oh[w_sel]  = 1'b1;
      end
    end
  end

  // Mux the winning source's access type, address and write data.
  always_comb begin
    w_win_write = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win_oh[i]) begin
        w_win_write = bus.write_req[i];
        w_win_addr  = bus.addr_table[i*ADDR_W +: ADDR_W];
        w_win_wdata = bus.write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue FSM. It registers the grant and SRAM command for the winner. When
  // idle, the address and data keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ISSUE: begin
          if (w_found) begin
            r_state <= ST_ISSUE;
            r_grant <= w_win_oh;
            r_wen   <= w_win_write;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_last  <= w_win_idx;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_wen   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

  // A read on the SRAM pins this cycle pushes its one-hot source tag.
  assign w_rd_push = (r_state == ST_ISSUE && !r_wen) ? r_grant : '0;

  // Tag shift register. Stage RD_LAT-1 lines up with mem_rdata for that read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_rd_push;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Saturating count of contended cycles and the sticky illegal-request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_contended && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_illegal <= r_illegal | w_illegal_now;
    end
  end

  assign bus.grant          = r_grant;
  assign bus.mem_en         = (r_state == ST_ISSUE);
  assign bus.mem_wen        = r_wen;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_wdata      = r_wdata;
  assign bus.rd_valid       = r_tag[RD_LAT-1];
  // Gated so that rd_data is zero when nothing is returned, including in reset.
  assign bus.rd_data        = (|r_tag[RD_LAT-1]) ? bus.mem_rdata : '0;
  assign bus.contention_cnt = r_cnt;
  assign bus.illegal_req    = r_illegal;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter. It includes a simple SRAM model with
// RD_LAT read latency.
module tb_mem_access_arbiter;

  localparam int NUM_SRC = 7;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 16;
  localparam int RD_LAT  = 2;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_access_arbiter_if #(
    .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) bus ();

  mem_access_arbiter #(
    .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write on mem_en & mem_wen; read data appears RD_LAT cycles later.
  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe   [RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wen) mem_model[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_wen) ? mem_model[bus.mem_addr] : '0;
    for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int src, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.addr_table[src*ADDR_W +: ADDR_W] = a;
    bus.write_data[src*DATA_W +: DATA_W] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},    32'(bus.grant),          32'h0);
    chk({tag, "_mem_en"},   32'(bus.mem_en),         32'h0);
    chk({tag, "_mem_wen"},  32'(bus.mem_wen),        32'h0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr),       32'h0);
    chk({tag, "_wdata"},    32'(bus.mem_wdata),      32'h0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid),       32'h0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),        32'h0);
    chk({tag, "_cnt"},      32'(bus.contention_cnt), 32'h0);
    chk({tag, "_illegal"},  32'(bus.illegal_req),    32'h0);
    chk({tag, "_state"},    32'(bus.dbg_state),      32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.arb_mode   = 1'b0;
    bus.read_req   = '0;
    bus.write_req  = '0;
    bus.addr_table = '0;
    bus.write_data = '0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Reset in the middle of a read: src4 reads 0x05A, reset lands one cycle after grant
    set_src(4, 11'h05A, 16'h0000);
    bus.read_req[4] = 1'b1;
    tick();
    chk("rst_rd_grant", 32'(bus.grant),    32'h10);
    chk("rst_rd_en",    32'(bus.mem_en),   32'h1);
    chk("rst_rd_addr",  32'(bus.mem_addr), 32'h05A);
    chk("rst_rd_wen",   32'(bus.mem_wen),  32'h0);
    bus.read_req[4] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < RD_LAT + 3; c++) begin
      tick();
      chk("post_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    end

    // Fixed priority: src2, src4, src6 in order
    bus.arb_mode = 1'b0;
    bus.read_req = 7'b1010100;
    tick();
    chk("fix_g0", 32'(bus.grant), 32'h04);
    chk("fix_state", 32'(bus.dbg_state), 32'h1);
    bus.read_req[2] = 1'b0;
    tick();
    chk("fix_g1", 32'(bus.grant), 32'h10);
    bus.read_req[4] = 1'b0;
    tick();
    chk("fix_g2", 32'(bus.grant), 32'h40);
    bus.read_req[6] = 1'b0;
    tick();
    chk("fix_idle", 32'(bus.grant), 32'h0);
    chk("fix_cnt", 32'(bus.contention_cnt), 32'h2);

    // Round-robin with all sources writing; last winner was src6, so src0 is next
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 11'(11'h100 + i), 16'(16'hB000 + i));
    bus.arb_mode  = 1'b1;
    bus.write_req = '1;
    for (int g = 0; g < 8; g++) begin
      tick();
      chk("rr_grant", 32'(bus.grant),    32'(1 << (g % NUM_SRC)));
      chk("rr_addr",  32'(bus.mem_addr), 32'(32'h100 + (g % NUM_SRC)));
      chk("rr_wen",   32'(bus.mem_wen),  32'h1);
    end
    bus.write_req = '0;
    tick();
    chk("rr_idle_en",   32'(bus.mem_en),   32'h0);
    chk("rr_hold_addr", 32'(bus.mem_addr), 32'h100);
    chk("rr_hold_data", 32'(bus.mem_wdata), 32'hB000);

    // Tagged read return: preload 0x010/0x020 via writes, then read from src1 and src5
    bus.arb_mode = 1'b0;
    set_src(1, 11'h010, 16'hAAAA);
    set_src(5, 11'h020, 16'h5555);
    bus.write_req = 7'b0100010;
    tick();
    chk("pre_w1", 32'(bus.grant), 32'h02);
    bus.write_req[1] = 1'b0;
    tick();
    chk("pre_w5", 32'(bus.grant), 32'h20);
    bus.write_req[5] = 1'b0;
    tick();
    chk("wr_no_rd_valid", 32'(bus.rd_valid), 32'h0);
    bus.read_req = 7'b0100010;
    tick();
    chk("tag_g1",    32'(bus.grant),    32'h02);
    chk("tag_addr1", 32'(bus.mem_addr), 32'h010);
    bus.read_req[1] = 1'b0;
    tick();
    chk("tag_g5",    32'(bus.grant),    32'h20);
    chk("tag_addr5", 32'(bus.mem_addr), 32'h020);
    chk("tag_early", 32'(bus.rd_valid), 32'h0);
    bus.read_req[5] = 1'b0;
    tick();
    chk("tag_v1", 32'(bus.rd_valid), 32'h02);
    chk("tag_d1", 32'(bus.rd_data),  32'hAAAA);
    tick();
    chk("tag_v5", 32'(bus.rd_valid), 32'h20);
    chk("tag_d5", 32'(bus.rd_data),  32'h5555);
    tick();
    chk("tag_done", 32'(bus.rd_valid), 32'h0);

    // Illegal request: src3 raises read and write together
    chk("illegal_before", 32'(bus.illegal_req), 32'h0);
    set_src(3, 11'h07F, 16'h1234);
    bus.read_req[3]  = 1'b1;
    bus.write_req[3] = 1'b1;
    tick();
    chk("ill_grant", 32'(bus.grant),       32'h08);
    chk("ill_wen",   32'(bus.mem_wen),     32'h1);
    chk("ill_addr",  32'(bus.mem_addr),    32'h07F);
    chk("ill_wdata", 32'(bus.mem_wdata),   32'h1234);
    chk("ill_flag",  32'(bus.illegal_req), 32'h1);
    bus.read_req[3]  = 1'b0;
    bus.write_req[3] = 1'b0;
    for (int c = 0; c < RD_LAT + 2; c++) begin
      tick();
      chk("ill_no_rd_valid", 32'(bus.rd_valid),    32'h0);
      chk("ill_sticky",      32'(bus.illegal_req), 32'h1);
    end

    // Saturation: three sources keep two eligible requests every cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("sat_cnt0",    32'(bus.contention_cnt), 32'h0);
    chk("sat_illegal", 32'(bus.illegal_req),    32'h0);
    bus.write_req = 7'b0000111;
    repeat (10) tick();
    chk("sat_cnt10", 32'(bus.contention_cnt), 32'd10);
    repeat (10) tick();
    chk("sat_cnt20", 32'(bus.contention_cnt), 32'd15);
    repeat (5) tick();
    chk("sat_hold", 32'(bus.contention_cnt), 32'd15);
    bus.write_req = '0;
    tick();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
